// File: rtl/ram_latency_model.sv
// Word-addressed backing RAM with a programmable access latency.
// It sits behind the memory controller and reports progress on ramstate
// (FREE/BUSY/ACCESS/ERROR). Each accepted request spends LAT cycles in BUSY,
// then one cycle in ACCESS.
// Optional feature macro: RAM_HOLD_ACCESS_EN. When it is defined, an identical
// request held after ACCESS stays in ACCESS with no added latency. When it is
// undefined, that request restarts with the full LAT BUSY cycles.
module ram_latency_model #(
  parameter int unsigned LAT   = 2,     // BUSY cycles before ACCESS, 0..15
  parameter int unsigned DEPTH = 16384  // 32-bit words
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  input  logic        ramREN,
  input  logic        ramWEN,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  // Encoding matches ramstate_t in the controller's type package.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int unsigned IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LatCnt = 4'(LAT);
  localparam logic [29:0] DepthW = 30'(DEPTH);
  localparam ramstate_t   StartState = (LAT == 0) ? ACCESS : BUSY;

`ifdef RAM_HOLD_ACCESS_EN
  localparam bit HoldAccess = 1'b1;
`else
  localparam bit HoldAccess = 1'b0;
`endif

  ramstate_t        state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             wr_q, wr_d;
  logic             start_req;

  logic             req_any;
  logic             req_valid;
  logic             misaligned;
  logic             out_of_range;
  logic             req_bad;
  logic             same_req;
  logic             mem_we;
  logic [IdxW-1:0]  idx_q;

  logic [31:0]      mem [DEPTH];

  // Request decode. Address checks apply only while something is requested.
  always_comb begin
    req_any      = ramREN | ramWEN;
    req_valid    = ramREN ^ ramWEN;
    misaligned   = (ramaddr[1:0] != 2'b00);
    out_of_range = (ramaddr[31:2] >= DepthW);
    req_bad      = (ramREN & ramWEN) | (req_any & (misaligned | out_of_range));
    // Same word and same op as the latched request.
    same_req     = req_valid & (ramaddr == addr_q) & (ramWEN == wr_q);
    idx_q        = addr_q[IdxW+1:2];
  end

  // Next-state logic. start_req collects every path that (re)latches a request.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    start_req = 1'b0;

    unique case (state_q)
      FREE, ERROR: begin
        // ERROR lingers only while the bad request is still on the bus.
        if (req_bad) begin
          state_d = ERROR;
        end else if (req_valid) begin
          start_req = 1'b1;
        end else begin
          state_d = FREE;
        end
      end

      BUSY: begin
        if (req_bad) begin
          state_d = ERROR;
        end else if (!req_valid) begin
          // Abandoned: nothing is committed.
          state_d = FREE;
        end else if (!same_req) begin
          // A different address or op is a new request.
          start_req = 1'b1;
        end else if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ACCESS: begin
        if (req_bad) begin
          state_d = ERROR;
        end else if (!req_valid) begin
          state_d = FREE;
        end else if (HoldAccess && same_req) begin
          state_d = ACCESS;
        end else begin
          start_req = 1'b1;
        end
      end

      default: begin
        state_d = FREE;
      end
    endcase

    if (start_req) begin
      addr_d  = ramaddr;
      wr_d    = ramWEN;
      cnt_d   = LatCnt;
      state_d = StartState;
    end
  end

  // State, counter and latched request. An async reset aborts any access.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FREE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
    end
  end

  // A write commits only if the controller still drives the same write at the end of ACCESS.
  always_comb begin
    mem_we = (state_q == ACCESS) & wr_q & ramWEN & ~ramREN & (ramaddr == addr_q);
  end

  // Storage array. It has no reset so that its contents survive nRST.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[idx_q] <= ramstore;
    end
  end

  // Read data is driven only during the ACCESS cycle of a read.
  always_comb begin
    ramstate = state_q;
    ramload  = 32'd0;
    if ((state_q == ACCESS) && !wr_q) begin
      ramload = mem[idx_q];
    end
  end

endmodule

// File: tb/tb_ram_latency_model.sv
// Self-checking bench for ram_latency_model: two instances (LAT=2 and LAT=0),
// a vector table for the LAT=2 handshake/error flow, and hand-written sequences
// for restart, abandon, reset-abort and held-read behaviour.
module tb_ram_latency_model;

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

`ifdef RAM_HOLD_ACCESS_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        ren2, wen2, ren0, wen0;
  logic [31:0] load2, load0;
  logic [1:0]  st2, st0;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  ram_latency_model #(.LAT(2), .DEPTH(16384)) dut2 (
    .CLK      (CLK),
    .nRST     (nRST),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramREN   (ren2),
    .ramWEN   (wen2),
    .ramload  (load2),
    .ramstate (st2)
  );

  ram_latency_model #(.LAT(0), .DEPTH(16384)) dut0 (
    .CLK      (CLK),
    .nRST     (nRST),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramREN   (ren0),
    .ramWEN   (wen0),
    .ramload  (load0),
    .ramstate (st0)
  );

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  st;
    logic [31:0] ld;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [1:0] s,
                              input logic [31:0] l);
    vec_t v;
    v.ren = r; v.wen = w; v.addr = a; v.data = d; v.st = s; v.ld = l;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] get_st(input int lat);
    return (lat == 2) ? st2 : st0;
  endfunction

  function automatic logic [31:0] get_ld(input int lat);
    return (lat == 2) ? load2 : load0;
  endfunction

  // Drive one DUT's request; the other instance is kept idle.
  task automatic drive(input int lat, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    ramaddr  = a;
    ramstore = d;
    ren2 = (lat == 2) ? r : 1'b0;
    wen2 = (lat == 2) ? w : 1'b0;
    ren0 = (lat == 0) ? r : 1'b0;
    wen0 = (lat == 0) ? w : 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int lat, input int n);
    drive(lat, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (n) next_cycle();
  endtask

  // Check the state and load of the current cycle, then advance one cycle.
  task automatic cyc(input int lat, input string name, input logic [1:0] es,
                     input logic [31:0] el);
    @(negedge CLK);
    check({name, "_state"}, 32'(get_st(lat)), 32'(es));
    check({name, "_load"}, get_ld(lat), el);
    next_cycle();
  endtask

  // Full handshake: hold the request until ACCESS is seen (bounded), then release.
  task automatic do_access(input int lat, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp, input string name);
    bit got;
    got = 1'b0;
    drive(lat, !wr, wr, a, d);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK);
      if (get_st(lat) == S_ACCESS) begin
        got = 1'b1;
        if (!wr) check({name, "_data"}, get_ld(lat), exp);
      end
      next_cycle();
    end
    check({name, "_reached_access"}, 32'(got), 32'd1);
    idle(lat, 2);
  endtask

  logic [1:0] hold_exp [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0;
    drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
    #12;
    check("reset_st2", 32'(st2), 32'(S_FREE));
    check("reset_ld2", load2, 32'd0);
    check("reset_st0", 32'(st0), 32'(S_FREE));
    check("reset_ld0", load0, 32'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    next_cycle();

    // Preload word 0 of the LAT=2 instance.
    do_access(2, 1'b1, 32'h0, 32'h0000F00D, 32'd0, "pre_w0");

    // Write/read at 0x40, then bad requests, then confirm word 0 was untouched.
    vt.push_back(mk(0, 1, 32'h40, 32'hDEADBEEF, S_FREE, 32'd0));
    vt.push_back(mk(0, 1, 32'h40, 32'hDEADBEEF, S_BUSY, 32'd0));
    vt.push_back(mk(0, 1, 32'h40, 32'hDEADBEEF, S_BUSY, 32'd0));
    vt.push_back(mk(0, 1, 32'h40, 32'hDEADBEEF, S_ACCESS, 32'd0));
    vt.push_back(mk(0, 0, 32'h0, 32'h0, HOLD ? S_ACCESS : S_BUSY, 32'd0));
    vt.push_back(mk(1, 0, 32'h40, 32'h0, S_FREE, 32'd0));
    vt.push_back(mk(1, 0, 32'h40, 32'h0, S_BUSY, 32'd0));
    vt.push_back(mk(1, 0, 32'h40, 32'h0, S_BUSY, 32'd0));
    vt.push_back(mk(1, 0, 32'h40, 32'h0, S_ACCESS, 32'hDEADBEEF));
    vt.push_back(mk(0, 0, 32'h0, 32'h0, HOLD ? S_ACCESS : S_BUSY,
                    HOLD ? 32'hDEADBEEF : 32'd0));
    vt.push_back(mk(1, 1, 32'h40, 32'h0BAD0BAD, S_FREE, 32'd0));
    vt.push_back(mk(0, 1, 32'h3, 32'h0BAD0BAD, S_ERROR, 32'd0));
    vt.push_back(mk(1, 0, 32'h10000, 32'h0, S_ERROR, 32'd0));
    vt.push_back(mk(0, 1, 32'h10000, 32'h0BAD0BAD, S_ERROR, 32'd0));
    vt.push_back(mk(0, 0, 32'h0, 32'h0, S_ERROR, 32'd0));
    vt.push_back(mk(0, 0, 32'h0, 32'h0, S_FREE, 32'd0));
    vt.push_back(mk(1, 0, 32'h0, 32'h0, S_FREE, 32'd0));
    vt.push_back(mk(1, 0, 32'h0, 32'h0, S_BUSY, 32'd0));
    vt.push_back(mk(1, 0, 32'h0, 32'h0, S_BUSY, 32'd0));
    vt.push_back(mk(1, 0, 32'h0, 32'h0, S_ACCESS, 32'h0000F00D));
    vt.push_back(mk(0, 0, 32'h0, 32'h0, HOLD ? S_ACCESS : S_BUSY,
                    HOLD ? 32'h0000F00D : 32'd0));
    vt.push_back(mk(0, 0, 32'h0, 32'h0, S_FREE, 32'd0));

    foreach (vt[i]) begin
      drive(2, vt[i].ren, vt[i].wen, vt[i].addr, vt[i].data);
      cyc(2, $sformatf("vec%0d", i), vt[i].st, vt[i].ld);
    end

    // LAT=0: ACCESS in the very next cycle, load cleared afterwards.
    do_access(0, 1'b1, 32'h0, 32'h00001234, 32'd0, "lat0_w");
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
    cyc(0, "lat0_c0", S_FREE, 32'd0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(0, "lat0_c1", S_ACCESS, 32'h00001234);
    cyc(0, "lat0_c2", S_FREE, 32'd0);

    // Restart: address changes in BUSY, ACCESS lands in cycle 4 with the new word.
    do_access(2, 1'b1, 32'h80, 32'h11110080, 32'd0, "pre_w80");
    do_access(2, 1'b1, 32'h84, 32'h22220084, 32'd0, "pre_w84");
    drive(2, 1'b1, 1'b0, 32'h80, 32'h0);
    cyc(2, "rst_c0", S_FREE, 32'd0);
    drive(2, 1'b1, 1'b0, 32'h84, 32'h0);
    cyc(2, "rst_c1", S_BUSY, 32'd0);
    cyc(2, "rst_c2", S_BUSY, 32'd0);
    cyc(2, "rst_c3", S_BUSY, 32'd0);
    cyc(2, "rst_c4", S_ACCESS, 32'h22220084);
    idle(2, 2);

    // Abandon: write dropped in BUSY is never committed.
    do_access(2, 1'b1, 32'h10, 32'h00000AAA, 32'd0, "pre_w10");
    drive(2, 1'b0, 1'b1, 32'h10, 32'h00000055);
    cyc(2, "abn_c0", S_FREE, 32'd0);
    cyc(2, "abn_c1", S_BUSY, 32'd0);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(2, "abn_c2", S_BUSY, 32'd0);
    cyc(2, "abn_c3", S_FREE, 32'd0);
    do_access(2, 1'b0, 32'h10, 32'h0, 32'h00000AAA, "abn_rd");

    // Reset during BUSY of a write aborts it.
    do_access(2, 1'b1, 32'h20, 32'h0000C0DE, 32'd0, "pre_w20");
    drive(2, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF);
    cyc(2, "rstab_c0", S_FREE, 32'd0);
    cyc(2, "rstab_c1", S_BUSY, 32'd0);
    @(negedge CLK);
    check("rstab_c2_state", 32'(st2), 32'(S_BUSY));
    #1;
    nRST = 1'b0;
    #1;
    check("rstab_async_state", 32'(st2), 32'(S_FREE));
    check("rstab_async_load", load2, 32'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(2, "rstab_after", S_FREE, 32'd0);
    do_access(2, 1'b0, 32'h20, 32'h0, 32'h0000C0DE, "rstab_rd");

    // Read held for 8 cycles.
    hold_exp = '{S_FREE, S_BUSY, S_BUSY, S_ACCESS, S_BUSY, S_BUSY, S_ACCESS, S_BUSY};
    if (HOLD) begin
      for (int i = 4; i < 8; i++) hold_exp[i] = S_ACCESS;
    end
    drive(2, 1'b1, 1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 8; i++) begin
      cyc(2, $sformatf("hold_c%0d", i), hold_exp[i],
          (hold_exp[i] == S_ACCESS) ? 32'hDEADBEEF : 32'd0);
    end
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(2, "hold_c8", HOLD ? S_ACCESS : S_BUSY, HOLD ? 32'hDEADBEEF : 32'd0);
    cyc(2, "hold_c9", S_FREE, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
